memory_stage: RTL

//   Y86-64 memory stage plus M->W pipeline register. Performs the data-memory read/write
//   for the instruction in M and registers stat/icode/valE/valM/dstE/dstM for writeback.

---
 rtl/y86_pkg.sv | 43 ++++
 rtl/memory_stage_data_memory.sv | 49 ++++
 rtl/memory_stage.sv | 98 +++++++++
 3 files changed

// File: rtl/y86_pkg.sv
// Shared Y86-64 constants for the memory stage: icodes, status codes,
// the no-register marker and the writeback bubble value.
package y86_pkg;

  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_RRMOVQ = 4'h2;
  localparam logic [3:0] I_IRMOVQ = 4'h3;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;

  localparam logic [2:0] S_AOK = 3'd1;
  localparam logic [2:0] S_HLT = 3'd2;
  localparam logic [2:0] S_ADR = 3'd3;
  localparam logic [2:0] S_INS = 3'd4;

  localparam logic [3:0] RNONE = 4'hF;

  typedef struct packed {
    logic [2:0]  stat;
    logic [3:0]  icode;
    logic [63:0] val_e;
    logic [63:0] val_m;
    logic [3:0]  dst_e;
    logic [3:0]  dst_m;
  } w_reg_t;

  localparam w_reg_t W_BUBBLE = '{
    stat:  S_AOK,
    icode: I_NOP,
    val_e: 64'd0,
    val_m: 64'd0,
    dst_e: RNONE,
    dst_m: RNONE
  };

endpackage

// File: rtl/memory_stage_data_memory.sv
// Byte-addressed little-endian data memory: 64-bit combinational read, write at posedge.
// Optional MEM_ALIGN_CHECK_EN also flags accesses whose addr[2:0] is non-zero.
module data_memory #(
  parameter int DMEM_BYTES = 1024,
  parameter int AW         = 10
) (
  input  logic        clk,
  input  logic [63:0] addr_i,
  input  logic [63:0] wdata_i,
  input  logic        we_i,
  output logic [63:0] rdata_o,
  output logic        addr_err_o
);

  logic [7:0]    mem_q [DMEM_BYTES];
  logic [AW-1:0] idx_s;
  logic          range_err_s;

  assign idx_s       = addr_i[AW-1:0];
  // Compare all 64 bits so huge addresses never alias into the array.
  assign range_err_s = (addr_i > 64'(DMEM_BYTES - 8));

`ifdef MEM_ALIGN_CHECK_EN
  assign addr_err_o = range_err_s | (addr_i[2:0] != 3'b000);
`else
  assign addr_err_o = range_err_s;
`endif

  always_comb begin
    rdata_o = 64'd0;
    for (int i = 0; i < 8; i++) begin
      rdata_o[8*i +: 8] = mem_q[idx_s + AW'(i)];
    end
  end

  // Memory is intentionally not reset; the caller gates we_i with rst_n.
  always_ff @(posedge clk) begin
    if (we_i) begin
      for (int i = 0; i < 8; i++) begin
        mem_q[idx_s + AW'(i)] <= wdata_i[8*i +: 8];
      end
    end else begin
      for (int i = 0; i < 8; i++) begin
        mem_q[idx_s + AW'(i)] <= mem_q[idx_s + AW'(i)];
      end
    end
  end

endmodule

// File: rtl/memory_stage.sv
// Y86-64 memory stage: access decode, data memory, and the M->W pipeline register.
// Build option MEM_ALIGN_CHECK_EN (in data_memory) makes unaligned accesses raise ADR.
module memory_stage
  import y86_pkg::*;
#(
  parameter int DMEM_BYTES = 1024,
  parameter int AW         = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [2:0]  M_stat,
  input  logic [3:0]  M_icode,
  input  logic [63:0] M_valE,
  input  logic [63:0] M_valA,
  input  logic [3:0]  M_dstE,
  input  logic [3:0]  M_dstM,
  input  logic        W_stall,
  input  logic        W_bubble,
  output logic [63:0] m_valM,
  output logic [2:0]  m_stat,
  output logic [2:0]  W_stat,
  output logic [3:0]  W_icode,
  output logic [63:0] W_valE,
  output logic [63:0] W_valM,
  output logic [3:0]  W_dstE,
  output logic [3:0]  W_dstM
);

  logic        rd_s;
  logic        wr_s;
  logic [63:0] addr_s;
  logic [63:0] rdata_s;
  logic        dm_err_s;
  logic        addr_err_s;
  logic        we_s;
  w_reg_t      w_d;
  w_reg_t      w_q;

  always_comb begin
    rd_s   = 1'b0;
    wr_s   = 1'b0;
    addr_s = M_valE;
    case (M_icode)
      I_MRMOVQ:              rd_s = 1'b1;
      I_POPQ, I_RET: begin
        rd_s   = 1'b1;
        addr_s = M_valA;
      end
      I_RMMOVQ, I_PUSHQ, I_CALL: wr_s = 1'b1;
      default: begin
        rd_s = 1'b0;
        wr_s = 1'b0;
      end
    endcase
  end

  data_memory #(.DMEM_BYTES(DMEM_BYTES), .AW(AW)) u_dmem (
    .clk        (clk),
    .addr_i     (addr_s),
    .wdata_i    (M_valA),
    .we_i       (we_s),
    .rdata_o    (rdata_s),
    .addr_err_o (dm_err_s)
  );

  assign addr_err_s = (rd_s | wr_s) & dm_err_s;
  assign we_s       = wr_s & (M_stat == S_AOK) & ~dm_err_s & rst_n;
  assign m_stat     = addr_err_s ? S_ADR : M_stat;
  assign m_valM     = (rd_s & ~addr_err_s) ? rdata_s : 64'd0;

  // Stall has priority over bubble.
  always_comb begin
    if (W_stall) begin
      w_d = w_q;
    end else if (W_bubble) begin
      w_d = W_BUBBLE;
    end else begin
      w_d = '{stat: m_stat, icode: M_icode, val_e: M_valE, val_m: m_valM,
              dst_e: M_dstE, dst_m: M_dstM};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      w_q <= W_BUBBLE;
    end else begin
      w_q <= w_d;
    end
  end

  assign W_stat  = w_q.stat;
  assign W_icode = w_q.icode;
  assign W_valE  = w_q.val_e;
  assign W_valM  = w_q.val_m;
  assign W_dstE  = w_q.dst_e;
  assign W_dstM  = w_q.dst_m;

endmodule
